// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage RISC-V pipeline.
// A RUN / LSTALL / WAIT FSM sequences multi-cycle load-use bubbles and freezes
// the pipeline while the memory port reports o_p_waitrequest.
// Optional build macro HAZARD_PERF_CNT_EN enables the 32-bit performance
// counters; without it stall_cnt/flush_cnt/wait_cnt are tied to zero.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,              // asynchronous, active-low
  input  logic [4:0]  RS1_D,
  input  logic [4:0]  RS2_D,
  input  logic [4:0]  RS1_E,
  input  logic [4:0]  RS2_E,
  input  logic [4:0]  RD_E,
  input  logic        ResultSrcE,
  input  logic        RegWriteE,
  input  logic        PCSrcE,
  input  logic [4:0]  RD_M,
  input  logic        RegWriteM,
  input  logic [4:0]  RD_W,
  input  logic        RegWriteW,
  input  logic        o_p_waitrequest,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic [1:0]  hz_state,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] wait_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_LSTALL = 2'b01,
    ST_WAIT   = 2'b10
  } state_t;

  localparam bit       MULTI_STALL = (LOAD_STALL_CYCLES > 1);
  localparam logic [3:0] CNT_RELOAD = 4'(LOAD_STALL_CYCLES - 1);

  // RegWriteE is part of the pipeline bundle but plays no role in hazard
  // detection: a load in execute always writes, and ALU results are forwarded
  // from later stages only.
  logic unused_regwrite_e;
  assign unused_regwrite_e = RegWriteE;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ret_lstall_q, ret_lstall_d;   // 1: return to LSTALL, 0: RUN

  logic       lw_hit;
  logic       stall_c, flush_d_c, flush_e_c;
  state_t     eff_state;
  state_t     hz_c;
  logic [1:0] fwd_a_c, fwd_b_c;

  // Load-use hazard: the load in execute produces a register decode needs.
  assign lw_hit = ResultSrcE && (RD_E != 5'd0) &&
                  ((RD_E == RS1_D) || (RD_E == RS2_D));

  // Operand forwarding; memory stage is newer than writeback so it wins.
  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if (RegWriteM && (RD_M != 5'd0) && (RD_M == RS1_E))
      fwd_a_c = 2'b10;
    else if (RegWriteW && (RD_W != 5'd0) && (RD_W == RS1_E))
      fwd_a_c = 2'b01;
    if (RegWriteM && (RD_M != 5'd0) && (RD_M == RS2_E))
      fwd_b_c = 2'b10;
    else if (RegWriteW && (RD_W != 5'd0) && (RD_W == RS2_E))
      fwd_b_c = 2'b01;
  end

  // Next-state and stall/flush decode; on WAIT exit the return state's
  // behaviour applies immediately to the current inputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ret_lstall_d = ret_lstall_q;
    stall_c      = 1'b0;
    flush_d_c    = 1'b0;
    flush_e_c    = 1'b0;
    eff_state    = (state_q == ST_WAIT) ? (ret_lstall_q ? ST_LSTALL : ST_RUN)
                                        : state_q;
    hz_c         = eff_state;

    if (o_p_waitrequest) begin
      // Freeze everything; the bubble counter does not advance.
      stall_c = 1'b1;
      state_d = ST_WAIT;
      hz_c    = ST_WAIT;
      if (state_q != ST_WAIT)
        ret_lstall_d = (state_q == ST_LSTALL);
    end else begin
      unique case (eff_state)
        ST_LSTALL: begin
          if (PCSrcE) begin
            // Taken branch squashes the stalled instruction; drop the stall.
            flush_d_c = 1'b1;
            flush_e_c = 1'b1;
            cnt_d     = 4'd0;
            state_d   = ST_RUN;
          end else begin
            stall_c   = 1'b1;
            flush_e_c = 1'b1;
            cnt_d     = cnt_q - 4'd1;
            state_d   = (cnt_q == 4'd1) ? ST_RUN : ST_LSTALL;
          end
        end
        default: begin
          state_d = ST_RUN;
          if (PCSrcE) begin
            flush_d_c = 1'b1;
            flush_e_c = 1'b1;
          end else if (lw_hit) begin
            stall_c   = 1'b1;
            flush_e_c = 1'b1;
            if (MULTI_STALL) begin
              state_d = ST_LSTALL;
              cnt_d   = CNT_RELOAD;
            end
          end
        end
      endcase
    end
  end

  // FSM state, bubble counter and return-state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      cnt_q        <= 4'd0;
      ret_lstall_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ret_lstall_q <= ret_lstall_d;
    end
  end

  // All outputs are held quiet while reset is asserted.
  assign StallF    = rst & stall_c;
  assign StallD    = rst & stall_c;
  assign FlushD    = rst & flush_d_c;
  assign FlushE    = rst & flush_e_c;
  assign ForwardAE = rst ? fwd_a_c : 2'b00;
  assign ForwardBE = rst ? fwd_b_c : 2'b00;
  assign hz_state  = rst ? hz_c : 2'b00;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
      wait_cnt_q  <= 32'd0;
    end else begin
      if (StallF && !o_p_waitrequest)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (FlushD)
        flush_cnt_q <= flush_cnt_q + 32'd1;
      if (o_p_waitrequest)
        wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`else
  assign stall_cnt = 32'h0;
  assign flush_cnt = 32'h0;
  assign wait_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: two instances (LOAD_STALL_CYCLES = 1 and 3) share
// the same stimulus; expected outputs are queued per cycle and popped when the
// outputs are sampled mid-cycle.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic       ResultSrcE, RegWriteE, PCSrcE, RegWriteM, RegWriteW, o_p_waitrequest;

  logic        stall_f1, stall_d1, flush_d1, flush_e1;
  logic [1:0]  fwd_a1, fwd_b1, hz1;
  logic [31:0] sc1, fc1, wc1;
  logic        stall_f3, stall_d3, flush_d3, flush_e3;
  logic [1:0]  fwd_a3, fwd_b3, hz3;
  logic [31:0] sc3, fc3, wc3;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
    .RD_E(RD_E), .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .PCSrcE(PCSrcE),
    .RD_M(RD_M), .RegWriteM(RegWriteM), .RD_W(RD_W), .RegWriteW(RegWriteW),
    .o_p_waitrequest(o_p_waitrequest), .StallF(stall_f1), .StallD(stall_d1),
    .FlushD(flush_d1), .FlushE(flush_e1), .ForwardAE(fwd_a1), .ForwardBE(fwd_b1),
    .hz_state(hz1), .stall_cnt(sc1), .flush_cnt(fc1), .wait_cnt(wc1));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
    .RD_E(RD_E), .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .PCSrcE(PCSrcE),
    .RD_M(RD_M), .RegWriteM(RegWriteM), .RD_W(RD_W), .RegWriteW(RegWriteW),
    .o_p_waitrequest(o_p_waitrequest), .StallF(stall_f3), .StallD(stall_d3),
    .FlushD(flush_d3), .FlushE(flush_e3), .ForwardAE(fwd_a3), .ForwardBE(fwd_b3),
    .hz_state(hz3), .stall_cnt(sc3), .flush_cnt(fc3), .wait_cnt(wc3));

  // {StallF, StallD, FlushD, FlushE, hz_state}
  logic [5:0] ctl1, ctl3;
  assign ctl1 = {stall_f1, stall_d1, flush_d1, flush_e1, hz1};
  assign ctl3 = {stall_f3, stall_d3, flush_d3, flush_e3, hz3};

  int total = 0;
  int bad   = 0;

  logic [5:0] q1[$];
  logic [5:0] q3[$];
  logic [3:0] qf[$];

  typedef struct packed {
    logic       wr;
    logic       br;
    logic       lw;
    logic [5:0] e1;
    logic [5:0] e3;
  } step_t;

  typedef struct packed {
    logic [4:0] rs1e;
    logic [4:0] rs2e;
    logic [4:0] rdm;
    logic       wm;
    logic [4:0] rdw;
    logic       ww;
    logic [3:0] exp_fwd;
  } fwd_t;

  // Drive one cycle of control stimulus; lw creates a hazard on RS2_D = 3.
  task automatic drive(input logic wr, input logic br, input logic lw);
    o_p_waitrequest = wr;
    PCSrcE          = br;
    ResultSrcE      = lw;
    RD_E            = lw ? 5'd3 : 5'd0;
    RS2_D           = lw ? 5'd3 : 5'd0;
    RS1_D           = 5'd7;
  endtask

  task automatic clear_fwd_inputs();
    RS1_E = 5'd0; RS2_E = 5'd0; RD_M = 5'd0; RD_W = 5'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; RegWriteE = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] e;
    logic [3:0] ef;
    drive(1'b0, 1'b0, 1'b1);
    RS1_E = 5'd5; RD_M = 5'd5; RegWriteM = 1'b1;
    q1.push_back(6'b0); q3.push_back(6'b0); qf.push_back(4'b0);
    #2;
    e = q1.pop_front(); total++;
    if (ctl1 !== e) begin bad++; $display("FAIL reset dut1 ctl got=%b want=%b", ctl1, e); end
    e = q3.pop_front(); total++;
    if (ctl3 !== e) begin bad++; $display("FAIL reset dut3 ctl got=%b want=%b", ctl3, e); end
    ef = qf.pop_front(); total++;
    if ({fwd_a1, fwd_b1} !== ef) begin bad++; $display("FAIL reset fwd got=%b want=%b", {fwd_a1, fwd_b1}, ef); end
    total++;
    if ({wc3, sc3, fc3} !== 96'd0) begin bad++; $display("FAIL reset counters got=%h want=0", {wc3, sc3, fc3}); end
    drive(1'b0, 1'b0, 1'b0);
    clear_fwd_inputs();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_forwarding();
    fwd_t tbl[6];
    logic [3:0] ef;
    tbl = '{
      '{5'd5, 5'd0, 5'd5, 1'b1, 5'd5, 1'b1, 4'b1000},
      '{5'd5, 5'd0, 5'd5, 1'b0, 5'd5, 1'b1, 4'b0100},
      '{5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 4'b0000},
      '{5'd4, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 4'b0010},
      '{5'd9, 5'd9, 5'd9, 1'b0, 5'd9, 1'b1, 4'b0101},
      '{5'd6, 5'd7, 5'd6, 1'b1, 5'd7, 1'b1, 4'b1001}
    };
    foreach (tbl[i]) begin
      RS1_E = tbl[i].rs1e; RS2_E = tbl[i].rs2e;
      RD_M = tbl[i].rdm; RegWriteM = tbl[i].wm;
      RD_W = tbl[i].rdw; RegWriteW = tbl[i].ww;
      qf.push_back(tbl[i].exp_fwd);
      #4;
      ef = qf.pop_front(); total++;
      if ({fwd_a1, fwd_b1} !== ef) begin
        bad++; $display("FAIL fwd[%0d] dut1 got=%b want=%b", i, {fwd_a1, fwd_b1}, ef);
      end
      total++;
      if ({fwd_a3, fwd_b3} !== ef) begin
        bad++; $display("FAIL fwd[%0d] dut3 got=%b want=%b", i, {fwd_a3, fwd_b3}, ef);
      end
      @(posedge clk); #1;
    end
    clear_fwd_inputs();
  endtask

  task automatic test_load_use();
    step_t tbl[4];
    logic [5:0] e;
    tbl = '{
      '{1'b0, 1'b0, 1'b1, 6'b110100, 6'b110100},
      '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b110101},
      '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b110101},
      '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000}
    };
    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].br, tbl[i].lw);
      q1.push_back(tbl[i].e1); q3.push_back(tbl[i].e3);
      #4;
      e = q1.pop_front(); total++;
      if (ctl1 !== e) begin bad++; $display("FAIL load_use c%0d dut1 ctl got=%b want=%b", i, ctl1, e); end
      e = q3.pop_front(); total++;
      if (ctl3 !== e) begin bad++; $display("FAIL load_use c%0d dut3 ctl got=%b want=%b", i, ctl3, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_over_load();
    step_t tbl[2];
    logic [5:0] e;
    tbl = '{
      '{1'b0, 1'b1, 1'b1, 6'b001100, 6'b001100},
      '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000}
    };
    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].br, tbl[i].lw);
      q1.push_back(tbl[i].e1); q3.push_back(tbl[i].e3);
      #4;
      e = q1.pop_front(); total++;
      if (ctl1 !== e) begin bad++; $display("FAIL branch_lw c%0d dut1 ctl got=%b want=%b", i, ctl1, e); end
      e = q3.pop_front(); total++;
      if (ctl3 !== e) begin bad++; $display("FAIL branch_lw c%0d dut3 ctl got=%b want=%b", i, ctl3, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wait_mid_stall();
    step_t tbl[8];
    logic [5:0] e;
    tbl = '{
      '{1'b0, 1'b0, 1'b1, 6'b110100, 6'b110100},
      '{1'b1, 1'b0, 1'b0, 6'b110010, 6'b110010},
      '{1'b1, 1'b0, 1'b0, 6'b110010, 6'b110010},
      '{1'b1, 1'b0, 1'b0, 6'b110010, 6'b110010},
      '{1'b1, 1'b0, 1'b0, 6'b110010, 6'b110010},
      '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b110101},
      '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b110101},
      '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000}
    };
    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].br, tbl[i].lw);
      q1.push_back(tbl[i].e1); q3.push_back(tbl[i].e3);
      #4;
      e = q1.pop_front(); total++;
      if (ctl1 !== e) begin bad++; $display("FAIL wait_stall c%0d dut1 ctl got=%b want=%b", i, ctl1, e); end
      e = q3.pop_front(); total++;
      if (ctl3 !== e) begin bad++; $display("FAIL wait_stall c%0d dut3 ctl got=%b want=%b", i, ctl3, e); end
      @(posedge clk); #1;
    end
  endtask

  // Wait and load-use together, hazard re-detected after wait, then a second load.
  task automatic test_back_to_back();
    step_t tbl[9];
    logic [5:0] e;
    tbl = '{
      '{1'b1, 1'b0, 1'b1, 6'b110010, 6'b110010},
      '{1'b1, 1'b0, 1'b1, 6'b110010, 6'b110010},
      '{1'b0, 1'b0, 1'b1, 6'b110100, 6'b110100},
      '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b110101},
      '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b110101},
      '{1'b0, 1'b0, 1'b1, 6'b110100, 6'b110100},
      '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b110101},
      '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b110101},
      '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000}
    };
    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].br, tbl[i].lw);
      q1.push_back(tbl[i].e1); q3.push_back(tbl[i].e3);
      #4;
      e = q1.pop_front(); total++;
      if (ctl1 !== e) begin bad++; $display("FAIL b2b c%0d dut1 ctl got=%b want=%b", i, ctl1, e); end
      e = q3.pop_front(); total++;
      if (ctl3 !== e) begin bad++; $display("FAIL b2b c%0d dut3 ctl got=%b want=%b", i, ctl3, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_in_lstall();
    step_t tbl[3];
    logic [5:0] e;
    tbl = '{
      '{1'b0, 1'b0, 1'b1, 6'b110100, 6'b110100},
      '{1'b0, 1'b1, 1'b0, 6'b001100, 6'b001101},
      '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000}
    };
    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].br, tbl[i].lw);
      q1.push_back(tbl[i].e1); q3.push_back(tbl[i].e3);
      #4;
      e = q1.pop_front(); total++;
      if (ctl1 !== e) begin bad++; $display("FAIL br_lstall c%0d dut1 ctl got=%b want=%b", i, ctl1, e); end
      e = q3.pop_front(); total++;
      if (ctl3 !== e) begin bad++; $display("FAIL br_lstall c%0d dut3 ctl got=%b want=%b", i, ctl3, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] e;
    logic [3:0] ef;
    drive(1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    // dut3 is now in LSTALL; add a forwarding match as well
    drive(1'b0, 1'b0, 1'b0);
    RS1_E = 5'd5; RD_M = 5'd5; RegWriteM = 1'b1;
    q3.push_back(6'b110101);
    #1;
    e = q3.pop_front(); total++;
    if (ctl3 !== e) begin bad++; $display("FAIL areset pre dut3 ctl got=%b want=%b", ctl3, e); end
    rst = 1'b0;
    q1.push_back(6'b0); q3.push_back(6'b0); qf.push_back(4'b0);
    #1;  // no clock edge in between
    e = q1.pop_front(); total++;
    if (ctl1 !== e) begin bad++; $display("FAIL areset dut1 ctl got=%b want=%b", ctl1, e); end
    e = q3.pop_front(); total++;
    if (ctl3 !== e) begin bad++; $display("FAIL areset dut3 ctl got=%b want=%b", ctl3, e); end
    ef = qf.pop_front(); total++;
    if ({fwd_a3, fwd_b3} !== ef) begin bad++; $display("FAIL areset fwd got=%b want=%b", {fwd_a3, fwd_b3}, ef); end
    clear_fwd_inputs();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      q1.push_back(6'b0); q3.push_back(6'b0);
      #4;
      e = q1.pop_front(); total++;
      if (ctl1 !== e) begin bad++; $display("FAIL areset post c%0d dut1 ctl got=%b want=%b", i, ctl1, e); end
      e = q3.pop_front(); total++;
      if (ctl3 !== e) begin bad++; $display("FAIL areset post c%0d dut3 ctl got=%b want=%b", i, ctl3, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_counters();
    logic [31:0] ew1, ef1, es1, ew3, ef3, es3;
`ifdef HAZARD_PERF_CNT_EN
    ew1 = 32'd5; ef1 = 32'd1; es1 = 32'd1;
    ew3 = 32'd5; ef3 = 32'd1; es3 = 32'd3;
`else
    ew1 = 32'd0; ef1 = 32'd0; es1 = 32'd0;
    ew3 = 32'd0; ef3 = 32'd0; es3 = 32'd0;
`endif
    #1 rst = 1'b0;
    #1;
    total++;
    if ({wc1, fc1, sc1, wc3, fc3, sc3} !== 192'd0) begin
      bad++; $display("FAIL cnt_reset got=%h want=0", {wc1, fc1, sc1, wc3, fc3, sc3});
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0, 1'b0); @(posedge clk); #1; end
    drive(1'b0, 1'b1, 1'b0); @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1); @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b0, 1'b0); @(posedge clk); #1; end
    total++;
    if (wc1 !== ew1) begin bad++; $display("FAIL wait_cnt dut1 got=%0d want=%0d", wc1, ew1); end
    total++;
    if (fc1 !== ef1) begin bad++; $display("FAIL flush_cnt dut1 got=%0d want=%0d", fc1, ef1); end
    total++;
    if (sc1 !== es1) begin bad++; $display("FAIL stall_cnt dut1 got=%0d want=%0d", sc1, es1); end
    total++;
    if (wc3 !== ew3) begin bad++; $display("FAIL wait_cnt dut3 got=%0d want=%0d", wc3, ew3); end
    total++;
    if (fc3 !== ef3) begin bad++; $display("FAIL flush_cnt dut3 got=%0d want=%0d", fc3, ef3); end
    total++;
    if (sc3 !== es3) begin bad++; $display("FAIL stall_cnt dut3 got=%0d want=%0d", sc3, es3); end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    clear_fwd_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_over_load();
    test_wait_mid_stall();
    test_back_to_back();
    test_branch_in_lstall();
    test_async_reset();
    test_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
